// File: rtl/measurement_sequencer.sv
// Single-qubit measurement sequencer: issues N shots to measurement_unit,
// tallies outcomes and writes back the collapsed state of the final shot.
module measurement_sequencer #(
    parameter int          SHOT_W    = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_1234,
    parameter int          TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [SHOT_W-1:0] num_shots,
    input  logic [31:0]       alpha_in,
    output logic              measure_en,
    output logic [31:0]       prob_0,
    output logic [31:0]       random_val,
    input  logic              measured_bit,
    input  logic              done,
    input  logic [31:0]       new_alpha,
    input  logic [31:0]       new_beta,
    output logic              busy,
    output logic              run_done,
    output logic              error,
    output logic [SHOT_W-1:0] count_zeros,
    output logic [SHOT_W-1:0] count_ones,
    output logic              state_we,
    output logic [31:0]       state_alpha,
    output logic [31:0]       state_beta
);

    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam int          TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SHOT_W-1:0] S1 = SHOT_W'(1);
    localparam logic [TO_W-1:0]   T1 = TO_W'(1);
    localparam logic [TO_W-1:0]   TLAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, FINISH} state_t;

    state_t             state;
    logic signed [31:0] alpha_q;
    logic [SHOT_W-1:0]  rem_q;
    logic [TO_W-1:0]    tcnt_q;
    logic [31:0]        lfsr_q;
    logic [31:0]        lfsr_nxt;
    logic signed [63:0] alpha_ext;
    logic signed [63:0] prod;
    logic               sat;
    logic [31:0]        prob_lo;

    // alpha^2 in Q30.32; anything at or above 1.0 clamps to 1.0
    assign alpha_ext = 64'(alpha_q);
    assign prod      = alpha_ext * alpha_ext;
    assign sat       = prod[63:32] != 32'h0;
    assign prob_lo   = 32'(prod >> 16);
    assign lfsr_nxt  = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 32'h0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            lfsr_q      <= LFSR_SEED;
            alpha_q     <= '0;
            rem_q       <= '0;
            tcnt_q      <= '0;
            measure_en  <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            error       <= 1'b0;
            state_we    <= 1'b0;
            count_zeros <= '0;
            count_ones  <= '0;
            prob_0      <= '0;
            random_val  <= '0;
            state_alpha <= ONE;
            state_beta  <= '0;
        end else begin
            measure_en <= 1'b0;
            run_done   <= 1'b0;
            state_we   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rem_q       <= num_shots;
                        alpha_q     <= alpha_in;
                        count_zeros <= '0;
                        count_ones  <= '0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    prob_0 <= sat ? ONE : prob_lo;
                    if (rem_q == '0) begin
                        run_done <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        measure_en <= 1'b1;
                        random_val <= {16'h0, lfsr_q[15:0]};
                        lfsr_q     <= lfsr_nxt;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    tcnt_q <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        if (measured_bit)
                            count_ones <= count_ones + S1;
                        else
                            count_zeros <= count_zeros + S1;
                        rem_q <= rem_q - S1;
                        if (rem_q == S1) begin
                            run_done    <= 1'b1;
                            state_we    <= 1'b1;
                            state_alpha <= new_alpha;
                            state_beta  <= new_beta;
                            state       <= FINISH;
                        end else begin
                            measure_en <= 1'b1;
                            random_val <= {16'h0, lfsr_q[15:0]};
                            lfsr_q     <= lfsr_nxt;
                            state      <= ISSUE;
                        end
                    end else if (tcnt_q == TLAST) begin
                        error    <= 1'b1;
                        run_done <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        tcnt_q <= tcnt_q + T1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_measurement_sequencer.sv
// Bench for measurement_sequencer: behavioural measurement_unit, vector
// table of runs, scoreboard of expected run results checked at run_done.
module tb_measurement_sequencer;

    localparam logic [31:0] ONE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] num_shots;
    logic [31:0] alpha_in;
    logic        measure_en;
    logic [31:0] prob_0;
    logic [31:0] random_val;
    logic        measured_bit;
    logic        done;
    logic [31:0] new_alpha;
    logic [31:0] new_beta;
    logic        busy;
    logic        run_done;
    logic        error;
    logic [15:0] count_zeros;
    logic [15:0] count_ones;
    logic        state_we;
    logic [31:0] state_alpha;
    logic [31:0] state_beta;

    measurement_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .num_shots(num_shots), .alpha_in(alpha_in),
        .measure_en(measure_en), .prob_0(prob_0), .random_val(random_val),
        .measured_bit(measured_bit), .done(done),
        .new_alpha(new_alpha), .new_beta(new_beta),
        .busy(busy), .run_done(run_done), .error(error),
        .count_zeros(count_zeros), .count_ones(count_ones),
        .state_we(state_we), .state_alpha(state_alpha),
        .state_beta(state_beta)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alpha;
        logic [15:0] n;
        logic [31:0] prob;
        int          sum;
        int          lo;
        int          hi;
        bit          we;
        bit          chk_state;
        logic [31:0] sa;
        logic [31:0] sb;
        int          lat;
        int          pulses;
        bit          err;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[5];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_edge = 0;
    int rd_cnt = 0;
    int pulses = 0;
    int gap_bad = 0;
    int last_me = -1;
    int we_seen = 0;
    bit mu_en = 1'b1;
    bit pend = 1'b0;
    logic [31:0] rv_q = '0;
    logic [31:0] pb_q = '0;

    task automatic check(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // responsive measurement_unit: result valid the cycle after measure_en
    always @(negedge clk) begin
        done = pend && mu_en;
        if (pend) begin
            measured_bit = rv_q >= pb_q;
            new_alpha    = measured_bit ? 32'h0 : ONE;
            new_beta     = measured_bit ? ONE : 32'h0;
        end
        pend = measure_en;
        rv_q = random_val;
        pb_q = prob_0;
    end

    always @(negedge clk) begin
        vec_t e;
        if (reset_n && measure_en) begin
            pulses++;
            if (last_me >= 0 && cyc - last_me != 2) gap_bad++;
            last_me = cyc;
        end
        if (reset_n && state_we) we_seen++;
        if (reset_n && run_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_run_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("latency", cyc - start_edge, e.lat);
                check("me_pulses", pulses, e.pulses);
                check("me_gap", gap_bad, 0);
                check("prob_0", prob_0, e.prob);
                check("count_sum", count_zeros + count_ones, e.sum);
                checks++;
                if (count_ones < e.lo || count_ones > e.hi) begin
                    errors++;
                    $display("FAIL count_ones: got %0d expected %0d..%0d",
                             count_ones, e.lo, e.hi);
                end
                check("state_we", state_we, e.we);
                check("we_count", we_seen, e.we);
                check("error", error, e.err);
                if (e.chk_state) begin
                    check("state_alpha", state_alpha, e.sa);
                    check("state_beta", state_beta, e.sb);
                end
            end
            rd_cnt++;
            pulses  = 0;
            gap_bad = 0;
            last_me = -1;
            we_seen = 0;
        end
    end

    task automatic start_run(input logic [31:0] a, input logic [15:0] n,
                             input vec_t e, input bit push);
        @(negedge clk);
        alpha_in   = a;
        num_shots  = n;
        start      = 1'b1;
        start_edge = cyc + 1;
        if (push) sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_run(input int budget);
        int rd0 = rd_cnt;
        int i = 0;
        while (rd_cnt == rd0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("run_done_seen", rd_cnt != rd0, 1);
    endtask

    initial begin
        vec_t e;
        reset_n   = 1'b0;
        start     = 1'b0;
        num_shots = '0;
        alpha_in  = '0;
        done = 1'b0;
        measured_bit = 1'b0;
        new_alpha = '0;
        new_beta  = '0;

        //      alpha         n     prob          sum  lo   hi  we cs  sa   sb   lat  pul err
        tbl[0] = '{ONE,          4, ONE,          4,   0,   0, 1, 1, ONE, 0,   9,    4,  0};
        tbl[1] = '{32'hFFFF_0000, 4, ONE,          4,   0,   0, 1, 1, ONE, 0,   9,    4,  0};
        tbl[2] = '{32'h0,        4, 32'h0,        4,   4,   4, 1, 1, 0,   ONE, 9,    4,  0};
        tbl[3] = '{32'h0000_B505, 1000, 32'h8000, 1000, 430, 570, 1, 0, 0, 0,   2001, 1000, 0};
        tbl[4] = '{ONE,          0, ONE,          0,   0,   0, 0, 0, 0,   0,   1,    0,  0};

        repeat (3) @(negedge clk);
        check("rst_measure_en", measure_en, 0);
        check("rst_busy", busy, 0);
        check("rst_run_done", run_done, 0);
        check("rst_error", error, 0);
        check("rst_state_we", state_we, 0);
        check("rst_count_zeros", count_zeros, 0);
        check("rst_count_ones", count_ones, 0);
        check("rst_prob_0", prob_0, 0);
        check("rst_random_val", random_val, 0);
        check("rst_state_alpha", state_alpha, ONE);
        check("rst_state_beta", state_beta, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            start_run(tbl[i].alpha, tbl[i].n, tbl[i], 1'b1);
            wait_run(2 * int'(tbl[i].n) + 40);
        end

        // measurement_unit stops answering: run aborts on timeout
        mu_en = 1'b0;
        e = '{ONE, 4, ONE, 0, 0, 0, 0, 0, 0, 0, 17, 1, 1};
        start_run(ONE, 4, e, 1'b1);
        wait_run(60);
        repeat (3) @(negedge clk);
        check("error_held", error, 1);
        mu_en = 1'b1;
        pend = 1'b0;

        // start while busy must not restart or relatch
        e = tbl[2];
        e.err = 1'b0;
        start_run(32'h0, 4, e, 1'b1);
        repeat (2) @(negedge clk);
        check("busy_mid_run", busy, 1);
        alpha_in  = ONE;
        num_shots = 16'd10;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_run(60);

        // reset mid-run: run abandoned, no run_done
        start_run(32'h0, 10, e, 1'b0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_measure_en", measure_en, 0);
        check("abort_count_ones", count_ones, 0);
        repeat (3) @(negedge clk);
        check("abort_state_alpha", state_alpha, ONE);
        pend = 1'b0;
        done = 1'b0;
        pulses  = 0;
        gap_bad = 0;
        last_me = -1;
        we_seen = 0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        start_run(tbl[2].alpha, tbl[2].n, tbl[2], 1'b1);
        wait_run(60);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
